usb_buf_arbiter: RTL and testbench
==================================

Name: usb_buf_arbiter

Overview:
- Shares one single-port 8-bit buffer RAM between two requesters: the USB host data path and the CPU.
- The host data path is the EPP front-end's data-register reads and writes at address 0.
- The host side uses an internal auto-incrementing, wrapping pointer. The CPU side uses explicit addresses.
- Sits between the USB front-end, the CPU bus and the buffer RAM. Arbitration is round-robin with one access in flight.

Parameters:
- DEPTH, 100, number of buffer bytes; valid addresses are 0..DEPTH-1.
- AW, 7, address width; must satisfy 2**AW >= DEPTH.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- host_req  input  1  host access request; level, held until host_ack
- host_we  input  1  1 = write, 0 = read; stable while host_req is high
- host_wdata  input  8  host write data
- host_ptr_clear  input  1  one-cycle pulse that sets the host pointer to 0
- host_ack  output  1  one-cycle completion pulse
- host_rdata  output  8  read data; valid while host_ack is high
- host_ptr  output  AW  current host pointer
- cpu_req  input  1  CPU access request; level, held until cpu_ack
- cpu_we  input  1  1 = write
- cpu_addr  input  AW  CPU buffer address
- cpu_wdata  input  8  CPU write data
- cpu_ack  output  1  one-cycle completion pulse
- cpu_rdata  output  8  read data; valid while cpu_ack is high
- cpu_err  output  1  pulses with cpu_ack when cpu_addr >= DEPTH
- mem_en  output  1  RAM enable
- mem_we  output  1  RAM write enable
- mem_addr  output  AW  RAM address
- mem_wdata  output  8  RAM write data
- mem_rdata  input  8  RAM read data; registered, valid 1 cycle after mem_en

Behaviour:
- Reset values:
  - FSM state IDLE; host_ptr 0; last_grant = CPU, so the host wins the first tie.
  - All acks, cpu_err, mem_en and mem_we are 0.
  - host_rdata, cpu_rdata, mem_addr and mem_wdata are 0.
- Reset mid-transaction: the transaction is abandoned, no ack is issued, and the requester must re-request.
- FSM states IDLE, ISSUE, ACK.
  - IDLE: when any req is high, pick the grantee and register it plus its we/addr/wdata; go to ISSUE.
  - Only one req high: that requester is granted.
  - Both reqs high: the requester that is not last_grant is granted, and last_grant is updated.
  - ISSUE: mem_en = 1, mem_we = latched we, mem_addr = host_ptr or cpu_addr, mem_wdata = latched data; go to ACK.
  - ACK: the grantee's ack = 1. On a read, its rdata = mem_rdata, registered at the ISSUE→ACK edge so it is valid throughout ACK. Go to IDLE.
- Latency: req sampled high in IDLE at cycle 0 → mem_en in cycle 1 → ack in cycle 2. Throughput is one access per 3 cycles.
- Outside ISSUE, mem_en and mem_we are 0. The non-granted ack stays 0.
- Requester rule: deassert req, or change it for a new access, in the cycle after ack. A req seen high in IDLE is a new request.
- Host pointer:
  - Advances once per completed host access (read or write), at the end of the ACK cycle.
  - Wraps from DEPTH-1 to 0.
- host_ptr_clear:
  - If it coincides with a host increment, clear wins: the result is 0, not 1.
  - If it arrives during ISSUE of a host access, the current access uses the old pointer and the pointer is then 0.
- CPU out-of-range (cpu_addr >= DEPTH):
  - ISSUE keeps mem_en = 0.
  - ACK still pulses, with cpu_err = 1 and cpu_rdata = 0. No RAM write occurs.
- The host pointer never leaves the range 0..DEPTH-1.
- Starvation: under continuous requests from both sides, grants strictly alternate.

Decomposition:
- Package usb_pkg:
  - state encoding localparams ST_IDLE / ST_ISSUE / ST_ACK
  - grant encoding GNT_HOST / GNT_CPU
  - BUF_DEPTH = 100 default
- One natural sub-module, rr_arb2: a 2-way round-robin picker with a last-grant register. Inputs are reqs and an advance strobe; the output is the grant.
- The pointer and FSM stay in usb_buf_arbiter.

Test Plan:
- Host writes 0xA5, 0x3C with no CPU traffic → mem writes at addr 0 and 1, host_ack in cycle 2 of each access, host_ptr = 2.
- CPU reads addr 1 after those writes → cpu_rdata = 0x3C with cpu_ack; host_ptr unchanged at 2.
- host_req and cpu_req rise in the same cycle after reset → host granted first, CPU second. With both held continuously for 6 accesses, grants are H,C,H,C,H,C.
- Host performs 101 sequential writes → host_ptr goes 99 → 0, and the 101st write lands at addr 0.
- host_ptr_clear pulsed in the ACK cycle of a host access at ptr = 5 → host_ptr = 0, not 6.
- CPU reads addr 120 → mem_en stays 0, cpu_ack = 1, cpu_err = 1, cpu_rdata = 0.
- Reset asserted during ISSUE → no ack, FSM is IDLE next cycle, host_ptr = 0.

Source files
------------

// File: rtl/usb_pkg.sv
// Shared types for the USB buffer arbiter.
// State and grant encodings plus the default buffer depth.
package usb_pkg;

  localparam int BUF_DEPTH = 100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_ACK   = 2'd2
  } state_e;

  typedef enum logic {
    GNT_HOST = 1'b0,
    GNT_CPU  = 1'b1
  } gnt_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker.
// On a tie the side that did not win last time is chosen.
module rr_arb2
  import usb_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req_host,
  input  logic req_cpu,
  input  logic advance,
  output logic gnt
);

  gnt_e last_q;
  gnt_e last_d;
  gnt_e gnt_w;

  always_comb begin
    gnt_w = GNT_HOST;
    unique case (1'b1)
      req_host && req_cpu:
        gnt_w = (last_q == GNT_CPU) ? GNT_HOST : GNT_CPU;
      req_cpu && !req_host:
        gnt_w = GNT_CPU;
      default:
        gnt_w = GNT_HOST;
    endcase
  end

  always_comb begin
    last_d = last_q;
    if (advance) last_d = gnt_w;
  end

  always_ff @(posedge clk) begin
    if (reset) last_q <= GNT_CPU;
    else       last_q <= last_d;
  end

  assign gnt = gnt_w;

endmodule

// File: rtl/usb_buf_arbiter.sv
// Shares one single-port byte buffer between the USB host path
// (auto-incrementing pointer) and the CPU (explicit addresses).
module usb_buf_arbiter
  import usb_pkg::*;
#(
  parameter int DEPTH = BUF_DEPTH,
  parameter int AW    = 7
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [7:0]    host_wdata,
  input  logic          host_ptr_clear,
  output logic          host_ack,
  output logic [7:0]    host_rdata,
  output logic [AW-1:0] host_ptr,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_wdata,
  output logic          cpu_ack,
  output logic [7:0]    cpu_rdata,
  output logic          cpu_err,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdata,
  input  logic [7:0]    mem_rdata
);

  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_MAX = AW'(DEPTH - 1);

  state_e        state_q, state_d;
  gnt_e          gnt_q, gnt_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic          oor_q, oor_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          clr_pend_q, clr_pend_d;

  logic arb_gnt;
  logic any_req;

  assign any_req = host_req || cpu_req;

  rr_arb2 u_arb (
    .clk      (clk),
    .reset    (reset),
    .req_host (host_req),
    .req_cpu  (cpu_req),
    .advance  ((state_q == ST_IDLE) && any_req),
    .gnt      (arb_gnt)
  );

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    oor_d      = oor_q;
    ptr_d      = ptr_q;
    clr_pend_d = clr_pend_q;
    host_ack   = 1'b0;
    host_rdata = '0;
    cpu_ack    = 1'b0;
    cpu_rdata  = '0;
    cpu_err    = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          gnt_d   = gnt_e'(arb_gnt);
          state_d = ST_ISSUE;
          if (gnt_e'(arb_gnt) == GNT_CPU) begin
            we_d    = cpu_we;
            addr_d  = cpu_addr;
            wdata_d = cpu_wdata;
            oor_d   = {1'b0, cpu_addr} >= DEPTH_W;
          end else begin
            we_d    = host_we;
            addr_d  = '0;
            wdata_d = host_wdata;
            oor_d   = 1'b0;
          end
        end
      end
      ST_ISSUE: begin
        mem_en    = !oor_q;
        mem_we    = we_q && !oor_q;
        mem_addr  = (gnt_q == GNT_HOST) ? ptr_q : addr_q;
        mem_wdata = wdata_q;
        state_d   = ST_ACK;
        // A clear during the host's own access must also cancel its increment.
        if (host_ptr_clear && gnt_q == GNT_HOST) clr_pend_d = 1'b1;
      end
      ST_ACK: begin
        state_d = ST_IDLE;
        if (gnt_q == GNT_HOST) begin
          host_ack   = 1'b1;
          host_rdata = we_q ? 8'h00 : mem_rdata;
          clr_pend_d = 1'b0;
          if (!clr_pend_q)
            ptr_d = (ptr_q == PTR_MAX) ? '0 : ptr_q + AW'(1);
        end else begin
          cpu_ack   = 1'b1;
          cpu_err   = oor_q;
          cpu_rdata = (we_q || oor_q) ? 8'h00 : mem_rdata;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (host_ptr_clear) ptr_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      gnt_q      <= GNT_HOST;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      oor_q      <= 1'b0;
      ptr_q      <= '0;
      clr_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      oor_q      <= oor_d;
      ptr_q      <= ptr_d;
      clr_pend_q <= clr_pend_d;
    end
  end

  assign host_ptr = ptr_q;

endmodule

// File: tb/tb_usb_buf_arbiter.sv
// Scoreboard bench for usb_buf_arbiter with a registered RAM model.
// Expected acks and RAM accesses are queued at drive time.
module tb_usb_buf_arbiter;
  import usb_pkg::*;

  localparam int DEPTH = 100;
  localparam int AW    = 7;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          host_req = 1'b0, host_we = 1'b0, host_ptr_clear = 1'b0;
  logic [7:0]    host_wdata = '0;
  logic          host_ack;
  logic [7:0]    host_rdata;
  logic [AW-1:0] host_ptr;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [7:0]    cpu_wdata = '0;
  logic          cpu_ack, cpu_err;
  logic [7:0]    cpu_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata = '0;

  always #5 clk = ~clk;

  usb_buf_arbiter #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .host_req(host_req), .host_we(host_we), .host_wdata(host_wdata),
    .host_ptr_clear(host_ptr_clear), .host_ack(host_ack),
    .host_rdata(host_rdata), .host_ptr(host_ptr),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .cpu_err(cpu_err), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  logic [7:0] ram [0:127];
  always @(posedge clk)
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end

  typedef struct { logic rd; logic [7:0] data; logic err; } ack_t;
  typedef struct { logic [AW-1:0] addr; logic we; logic [7:0] wdata; } mem_t;

  ack_t hq[$];
  ack_t cq[$];
  mem_t mq[$];
  bit   gl[$];
  logic [7:0] mdl [0:127];
  int   exp_ptr = 0;
  bit   mem_chk = 1'b1;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  ack_t ea, eb;
  mem_t em;
  always @(negedge clk) begin
    if (host_ack && cpu_ack) chk("dual_ack", 1, 0);
    if (host_ack) begin
      gl.push_back(1'b0);
      if (hq.size() == 0) chk("host_ack_unexp", 1, 0);
      else begin
        ea = hq.pop_front();
        if (ea.rd) chk("host_rdata", host_rdata, ea.data);
      end
    end
    if (cpu_ack) begin
      gl.push_back(1'b1);
      if (cq.size() == 0) chk("cpu_ack_unexp", 1, 0);
      else begin
        eb = cq.pop_front();
        chk("cpu_err", cpu_err, eb.err);
        if (eb.rd) chk("cpu_rdata", cpu_rdata, eb.data);
      end
    end
    if (mem_en && mem_chk) begin
      if (mq.size() == 0) chk("mem_en_unexp", 1, 0);
      else begin
        em = mq.pop_front();
        chk("mem_addr", mem_addr, em.addr);
        chk("mem_we", mem_we, em.we);
        if (em.we) chk("mem_wdata", mem_wdata, em.wdata);
      end
    end
  end

  task automatic host_op(input logic we, input logic [7:0] wd, input bit solo);
    ack_t a;
    mem_t m;
    int n;
    host_we = we; host_wdata = wd; host_req = 1'b1;
    a.rd = !we; a.data = mdl[exp_ptr]; a.err = 1'b0;
    hq.push_back(a);
    if (mem_chk) begin
      m.addr = AW'(exp_ptr); m.we = we; m.wdata = wd;
      mq.push_back(m);
    end
    if (we) mdl[exp_ptr] = wd;
    exp_ptr = (exp_ptr == DEPTH - 1) ? 0 : exp_ptr + 1;
    n = 0;
    do begin @(negedge clk); n++; end while (!host_ack && n < 16);
    if (!host_ack) chk("host_tmo", 0, 1);
    else if (solo) chk("host_lat", n, 3);
    @(posedge clk); #1;
  endtask

  task automatic cpu_op(input logic we, input int addr, input logic [7:0] wd,
                        input bit solo);
    ack_t a;
    mem_t m;
    int n;
    bit oor;
    oor = addr >= DEPTH;
    cpu_we = we; cpu_addr = AW'(addr); cpu_wdata = wd; cpu_req = 1'b1;
    a.rd = !we; a.data = oor ? 8'h00 : mdl[addr]; a.err = oor;
    cq.push_back(a);
    if (!oor && mem_chk) begin
      m.addr = AW'(addr); m.we = we; m.wdata = wd;
      mq.push_back(m);
    end
    if (we && !oor) mdl[addr] = wd;
    n = 0;
    do begin @(negedge clk); n++; end while (!cpu_ack && n < 16);
    if (!cpu_ack) chk("cpu_tmo", 0, 1);
    else if (solo) chk("cpu_lat", n, 3);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; host_req = 1'b0; cpu_req = 1'b0; host_ptr_clear = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    exp_ptr = 0;
    mq.delete();
  endtask

  task automatic wait_sig(input bit use_mem);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end
    while (!(use_mem ? mem_en : host_ack) && n < 16);
    if (n >= 16) chk("wait_tmo", 0, 1);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) begin ram[i] = 8'h00; mdl[i] = 8'h00; end

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ctl", {host_ack, cpu_ack, cpu_err, mem_en, mem_we}, 0);
    chk("rst_ptr", host_ptr, 0);
    chk("rst_data", {host_rdata, cpu_rdata, mem_wdata}, 0);
    chk("rst_addr", mem_addr, 0);
    @(posedge clk); #1 reset = 1'b0;

    host_op(1'b1, 8'hA5, 1'b1);
    host_op(1'b1, 8'h3C, 1'b1);
    host_req = 1'b0;
    chk("ptr_after_2", host_ptr, 2);
    cpu_op(1'b0, 1, 8'h00, 1'b1);
    cpu_req = 1'b0;
    chk("ptr_after_cpu", host_ptr, 2);
    cpu_op(1'b1, 3, 8'h77, 1'b1);
    cpu_req = 1'b0;
    host_op(1'b0, 8'h00, 1'b1);
    host_op(1'b0, 8'h00, 1'b1);
    host_req = 1'b0;
    chk("ptr_after_rd", host_ptr, 4);

    do_reset();
    mem_chk = 1'b0;
    gl.delete();
    fork
      begin
        for (int i = 0; i < 3; i++) host_op(1'b1, 8'(8'h10 + i), 1'b0);
        host_req = 1'b0;
      end
      begin
        for (int j = 0; j < 3; j++) cpu_op(1'b1, 60 + j, 8'(8'h20 + j), 1'b0);
        cpu_req = 1'b0;
      end
    join
    mem_chk = 1'b1;
    chk("gnt_count", gl.size(), 6);
    for (int i = 0; i < 6 && i < gl.size(); i++)
      chk("gnt_order", gl[i], i % 2);
    chk("ptr_contend", host_ptr, 3);
    cpu_op(1'b0, 61, 8'h00, 1'b1);
    cpu_op(1'b0, 1, 8'h00, 1'b1);
    cpu_req = 1'b0;

    do_reset();
    for (int i = 0; i < 101; i++) begin
      host_op(1'b1, 8'(i), 1'b1);
      if (i == 98) chk("ptr_99", host_ptr, 99);
      if (i == 99) chk("ptr_wrap", host_ptr, 0);
    end
    host_req = 1'b0;
    chk("ptr_after_101", host_ptr, 1);
    cpu_op(1'b0, 0, 8'h00, 1'b1);
    cpu_op(1'b0, 99, 8'h00, 1'b1);
    cpu_req = 1'b0;

    do_reset();
    for (int i = 0; i < 5; i++) host_op(1'b1, 8'(8'h40 + i), 1'b1);
    chk("ptr_5", host_ptr, 5);
    fork
      host_op(1'b1, 8'h55, 1'b1);
      begin
        wait_sig(1'b0);
        host_ptr_clear = 1'b1;
        @(posedge clk); #1 host_ptr_clear = 1'b0;
      end
    join
    host_req = 1'b0;
    exp_ptr = 0;
    chk("clr_in_ack", host_ptr, 0);

    host_op(1'b1, 8'h61, 1'b1);
    host_op(1'b1, 8'h62, 1'b1);
    fork
      host_op(1'b1, 8'h66, 1'b1);
      begin
        wait_sig(1'b1);
        host_ptr_clear = 1'b1;
        @(posedge clk); #1 host_ptr_clear = 1'b0;
      end
    join
    host_req = 1'b0;
    exp_ptr = 0;
    chk("clr_in_issue", host_ptr, 0);
    cpu_op(1'b0, 2, 8'h00, 1'b1);

    cpu_op(1'b0, 120, 8'h00, 1'b1);
    cpu_op(1'b1, 120, 8'hEE, 1'b1);
    cpu_op(1'b0, 100, 8'h00, 1'b1);
    cpu_req = 1'b0;

    host_op(1'b1, 8'h99, 1'b1);
    chk("ptr_pre_rst", host_ptr, 1);
    host_we = 1'b1; host_wdata = 8'h42; host_req = 1'b1;
    em.addr = AW'(1); em.we = 1'b1; em.wdata = 8'h42;
    mq.push_back(em);
    mdl[1] = 8'h42;
    wait_sig(1'b1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; host_req = 1'b0; exp_ptr = 0;
    @(negedge clk);
    chk("rst_issue_idle", {host_ack, mem_en}, 0);
    chk("rst_issue_ptr", host_ptr, 0);
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
    host_op(1'b0, 8'h00, 1'b1);
    host_req = 1'b0;
    cpu_op(1'b0, 1, 8'h00, 1'b1);
    cpu_req = 1'b0;
    repeat (2) @(negedge clk);
    chk("hq_drained", hq.size(), 0);
    chk("cq_drained", cq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
